pc_sel_unit: RTL and testbench
==============================

// Module: pc_sel_unit
// PURPOSE
//  Next-generation PC stage: registered PC plus NSRC-way next-PC selection (sequential PC+4,
//  branch/jump targets, register-jump targets, EPC, ...). Unlike a bare PC mux, it holds the PC
//  under stall, buffers a redirect that arrives while stalled, and takes an exception redirect
//  with top priority. Sits at the head of F; pc drives IM and the F/D pipeline register.
// PARAMETERS
//  WIDTH     32            PC width in bits
//  NSRC      4             number of next-PC sources; index 0 = internal PC+4
//  SELW      2             width of sel; must satisfy 2**SELW >= NSRC
//  RESET_PC  32'h0000_3000 PC loaded on reset
//  EXC_PC    32'h0000_4180 PC loaded on exc_req
// PORTS
//  clk        in   1                 clock, all state updates on posedge
//  reset      in   1                 synchronous, active-low reset (0 = reset)
//  stall      in   1                 1 = hold PC this cycle
//  sel        in   SELW              next-PC source; 0 = PC+4; >=NSRC treated as 0
//  src_flat   in   (NSRC-1)*WIDTH    targets for sel 1..NSRC-1; sel k at bits [k*WIDTH-1 -: WIDTH]
//  exc_req    in   1                 exception/interrupt redirect request
//  pc         out  WIDTH             current fetch PC (registered)
//  pc_plus4   out  WIDTH             pc + 4, combinational, modulo 2**WIDTH
//  pending    out  1                 1 = a redirect is buffered and waiting for stall to drop
//  misalign   out  1                 registered: pc[1:0] != 0 (ALIGN_CHECK_EN only)
// BEHAVIOUR
//  - Reset (reset==0 at posedge): pc<=RESET_PC, state<=RUN, buf<=0, pending<=0, misalign<=0.
//  - Priority per cycle: reset > exc_req > buffered redirect > sel.
//  - exc_req=1: pc<=EXC_PC even if stall=1; state<=RUN; buf cleared; pending<=0.
//  - State RUN, stall=0: pc<=(sel==0 || sel>=NSRC) ? pc_plus4 : src[sel].
//  - State RUN, stall=1, sel!=0 (valid): buf<=src[sel], state<=PENDING, pending<=1; pc holds.
//  - State RUN, stall=1, sel==0: pc holds, nothing buffered.
//  - State PENDING, stall=1: pc holds; a new valid sel!=0 overwrites buf (newest redirect wins).
//  - State PENDING, stall=0: pc<=buf, state<=RUN, pending<=0; sel in that cycle is ignored.
//  - pc+4 wraps silently at 2**WIDTH (e.g. 32'hFFFF_FFFC -> 0); no overflow flag.
//  - Latency: selected target appears on pc one cycle after the sampling edge; buffered
//    redirect appears on the first edge at which stall==0.
//  - Reset asserted while in PENDING discards buf; the reset value of every output is as above.
// CONFIGURATION
//  ALIGN_CHECK_EN defined: misalign<=(next pc[1:0]!=0), updated with pc; pc still loads
//    the misaligned value (the exception unit raises AdEL from misalign and drives exc_req).
//  ALIGN_CHECK_EN undefined: misalign tied to 0, no check logic.
// STRUCTURE
//  Package pc_sel_pkg: RESET_PC/EXC_PC defaults, SEL_SEQ=0, state encoding RUN=1'b0 /
//    PENDING=1'b1.
//  Sub-module pc_redirect_buf: one-entry buffer + RUN/PENDING FSM (load/overwrite/release/
//    clear, outputs buf, pending). Top holds the PC register, source mux and PC+4 adder.
// TESTING
//  1 reset=0 one edge, then reset=1, stall=0, sel=0 x3 -> pc 0x3000,0x3004,0x3008,0x300C.
//  2 pc=0x3010, sel=1, src1=0x3400, stall=0 -> next pc=0x3400, pending=0.
//  3 stall=1 + sel=2 (src2=0x3800) one cycle, stall=1 two more cycles with sel=0 ->
//    pc held, pending=1; stall=0 -> pc=0x3800, pending=0.
//  4 PENDING with buf=0x3800, stall=1, sel=1 (src1=0x3A00), then stall=0 -> pc=0x3A00.
//  5 PENDING + stall=1 + exc_req=1 -> pc=0x4180, pending=0; buf not released later.
//  6 pc=32'hFFFF_FFFC, sel=0 -> pc=0; with ALIGN_CHECK_EN, sel=1, src1=0x3002 ->
//    pc=0x3002, misalign=1; without it misalign stays 0.

Source files
------------

// File: rtl/pc_sel_pkg.sv
// pc_sel_pkg: shared constants and state encoding for the next-PC stage.
//   RESET_PC_DEF / EXC_PC_DEF : default reset and exception-vector PCs
//   SEL_SEQ                   : sel value that picks sequential PC+4
//   redir_state_t             : RUN / PENDING state of the redirect buffer
package pc_sel_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
    localparam int unsigned SEL_SEQ      = 0;

    typedef enum logic {
        RUN     = 1'b0,
        PENDING = 1'b1
    } redir_state_t;

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry redirect buffer with RUN/PENDING FSM.
// A redirect requested while stalled is captured here and released on the
// first unstalled cycle; a newer redirect during the stall overwrites it.
// Ports:
//   clk, reset (sync, active-low)
//   clear        exception redirect: drop any buffered target
//   stall        pipeline stall
//   load_req     a valid non-sequential sel is present this cycle
//   target       target selected by sel
//   redirect_pc  buffered target
//   pending      1 while a target is buffered (state PENDING)
module pc_redirect_buf
    import pc_sel_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             stall,
    input  logic             load_req,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             pending
);

    redir_state_t     state, state_n;
    logic [WIDTH-1:0] redirect_n;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= RUN;
            redirect_pc <= '0;
        end else begin
            state       <= state_n;
            redirect_pc <= redirect_n;
        end
    end

    always_comb begin
        state_n    = state;
        redirect_n = redirect_pc;
        if (clear) begin
            state_n    = RUN;
            redirect_n = '0;
        end else begin
            case (state)
                RUN: begin
                    if (stall && load_req) begin
                        redirect_n = target;
                        state_n    = PENDING;
                    end
                end
                PENDING: begin
                    // Release happens in the top (pc <= redirect_pc); sel is ignored then.
                    if (!stall) begin
                        state_n = RUN;
                    end else if (load_req) begin
                        redirect_n = target;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    assign pending = (state == PENDING);

endmodule

// File: rtl/pc_sel_unit.sv
// pc_sel_unit: registered fetch PC with NSRC-way next-PC selection.
// Priority each cycle: reset > exc_req > buffered redirect > sel.
// Optional feature macro: ALIGN_CHECK_EN (registered misalign flag).
// Ports:
//   clk, reset (sync, active-low)
//   stall     hold PC this cycle
//   sel       next-PC source, 0 or >=NSRC = PC+4
//   src_flat  targets for sel 1..NSRC-1, sel k at [k*WIDTH-1 -: WIDTH]
//   exc_req   exception redirect to EXC_PC (overrides stall)
//   pc        current fetch PC
//   pc_plus4  pc + 4, wraps modulo 2**WIDTH
//   pending   a redirect is buffered behind a stall
//   misalign  pc[1:0] != 0 (only with ALIGN_CHECK_EN, else 0)
module pc_sel_unit
    import pc_sel_pkg::*;
#(
    parameter int unsigned     WIDTH    = 32,
    parameter int unsigned     NSRC     = 4,
    parameter int unsigned     SELW     = 2,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEF),
    parameter logic [WIDTH-1:0] EXC_PC   = WIDTH'(EXC_PC_DEF)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [SELW-1:0]             sel,
    input  logic [(NSRC-1)*WIDTH-1:0]   src_flat,
    input  logic                        exc_req,
    output logic [WIDTH-1:0]            pc,
    output logic [WIDTH-1:0]            pc_plus4,
    output logic                        pending,
    output logic                        misalign
);

    int unsigned      sel_idx;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_target;
    logic [WIDTH-1:0] redirect_pc;
    logic [WIDTH-1:0] next_pc;

    assign pc_plus4  = pc + WIDTH'(4);
    assign sel_idx   = 32'(sel);
    assign sel_valid = (sel_idx != SEL_SEQ) && (sel_idx < NSRC);

    always_comb begin
        sel_target = '0;
        for (int unsigned k = 1; k < NSRC; k++) begin
            if (sel_idx == k) begin
                sel_target = src_flat[k*WIDTH-1 -: WIDTH];
            end
        end
    end

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redirect_buf (
        .clk         (clk),
        .reset       (reset),
        .clear       (exc_req),
        .stall       (stall),
        .load_req    (sel_valid),
        .target      (sel_target),
        .redirect_pc (redirect_pc),
        .pending     (pending)
    );

    always_comb begin
        if (exc_req) begin
            next_pc = EXC_PC;
        end else if (stall) begin
            next_pc = pc;
        end else if (pending) begin
            next_pc = redirect_pc;
        end else if (sel_valid) begin
            next_pc = sel_target;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= next_pc;
        end
    end

`ifdef ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            misalign <= 1'b0;
        end else begin
            misalign <= (next_pc[1:0] != 2'b00);
        end
    end
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sel_unit.sv
module tb_pc_sel_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [1:0]  sel;
    logic [95:0] src_flat;
    logic        exc_req;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        pending;
    logic        misalign;

    logic [31:0] src1, src2, src3;
    assign src_flat = {src3, src2, src1};

`ifdef ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        ma;
        int          step_no;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_cnt = 0;

    pc_sel_unit #(
        .WIDTH    (32),
        .NSRC     (4),
        .SELW     (2),
        .RESET_PC (32'h0000_3000),
        .EXC_PC   (32'h0000_4180)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .sel      (sel),
        .src_flat (src_flat),
        .exc_req  (exc_req),
        .pc       (pc),
        .pc_plus4 (pc_plus4),
        .pending  (pending),
        .misalign (misalign)
    );

    always #5 clk = ~clk;

    // Drive inputs at a negedge, push the state expected after the next posedge.
    task automatic step(input logic rst, input logic st, input logic ex,
                        input logic [1:0] s, input logic [31:0] epc, input logic ep);
        exp_t e;
        reset   = rst;
        stall   = st;
        exc_req = ex;
        sel     = s;
        e.pc      = epc;
        e.pend    = ep;
        e.ma      = ALIGN ? (epc[1:0] != 2'b00) : 1'b0;
        e.step_no = step_cnt;
        step_cnt++;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic check(input string name, input int sn, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%08h, required 0x%08h", name, sn, act, req);
        end
    endtask

    // Monitor: the DUT presents a new PC every cycle, compare just after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pc",       e.step_no, pc,               e.pc);
                check("pc_plus4", e.step_no, pc_plus4,         e.pc + 32'd4);
                check("pending",  e.step_no, {31'd0, pending}, {31'd0, e.pend});
                check("misalign", e.step_no, {31'd0, misalign}, {31'd0, e.ma});
            end
        end
    end

    initial begin
        reset = 1'b0; stall = 1'b0; exc_req = 1'b0; sel = 2'd0;
        src1 = '0; src2 = '0; src3 = '0;
        @(negedge clk);

        // reset, then sequential fetch
        step(0, 0, 0, 2'd0, 32'h0000_3000, 0);
        step(1, 0, 0, 2'd0, 32'h0000_3004, 0);
        step(1, 0, 0, 2'd0, 32'h0000_3008, 0);
        step(1, 0, 0, 2'd0, 32'h0000_300C, 0);
        step(1, 0, 0, 2'd0, 32'h0000_3010, 0);
        // direct redirect
        src1 = 32'h0000_3400; src2 = 32'h0000_3800;
        step(1, 0, 0, 2'd1, 32'h0000_3400, 0);
        // redirect under stall is buffered, released when stall drops; sel ignored then
        step(1, 1, 0, 2'd2, 32'h0000_3400, 1);
        step(1, 1, 0, 2'd0, 32'h0000_3400, 1);
        step(1, 1, 0, 2'd0, 32'h0000_3400, 1);
        step(1, 0, 0, 2'd1, 32'h0000_3800, 0);
        // newest redirect wins
        step(1, 1, 0, 2'd2, 32'h0000_3800, 1);
        src1 = 32'h0000_3A00;
        step(1, 1, 0, 2'd1, 32'h0000_3800, 1);
        step(1, 0, 0, 2'd0, 32'h0000_3A00, 0);
        // exception while pending clears buffer, overrides stall
        step(1, 1, 0, 2'd2, 32'h0000_3A00, 1);
        step(1, 1, 1, 2'd0, 32'h0000_4180, 0);
        step(1, 1, 0, 2'd0, 32'h0000_4180, 0);
        step(1, 0, 0, 2'd0, 32'h0000_4184, 0);
        // highest source, exception beats sel
        src3 = 32'h0000_5000;
        step(1, 0, 0, 2'd3, 32'h0000_5000, 0);
        step(1, 0, 1, 2'd1, 32'h0000_4180, 0);
        // wrap of pc+4
        src1 = 32'hFFFF_FFFC;
        step(1, 0, 0, 2'd1, 32'hFFFF_FFFC, 0);
        step(1, 0, 0, 2'd0, 32'h0000_0000, 0);
        // misaligned target
        src1 = 32'h0000_3002;
        step(1, 0, 0, 2'd1, 32'h0000_3002, 0);
        step(1, 0, 0, 2'd0, 32'h0000_3006, 0);
        // reset while pending discards buffer
        src1 = 32'h0000_3C00;
        step(1, 1, 0, 2'd1, 32'h0000_3006, 1);
        step(0, 1, 0, 2'd0, 32'h0000_3000, 0);
        step(1, 0, 0, 2'd0, 32'h0000_3004, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
